seg7_scan_mux: RTL and testbench

- Parametrised time-multiplexed 7-segment display scanner for the board top level.
- Drives DIGITS common-enable digits from one shared segment bus plus a DP line, and performs hex-to-segment encoding.
- Adds several features: configurable dwell per digit, a ghost-suppression blanking window, tear-free double-buffered loading, leading-zero blanking and selectable output polarities.

---
 rtl/seg7_scan_mux_if.sv | 39 +++
 rtl/seg7_scan_mux.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Bus bundle for seg7_scan_mux.
//   master: the side that supplies display data (value, dp_in, load, lz_blank)
//           and observes the scanner outputs.
//   slave : the scanner itself.
// Signals:
//   value       4*DIGITS hex nibbles, nibble i drives digit i
//   dp_in       decimal point request per digit
//   load        single-cycle strobe capturing value/dp_in into staging
//   lz_blank    1 = blank leading zero digits
//   seg         segments {a,b,c,d,e,f,g}
//   dp          decimal point
//   en          digit enables
//   scan_idx    digit currently in slot
//   frame_start one-cycle pulse on the first output cycle of slot 0
interface seg7_scan_mux_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                lz_blank;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   en;
  logic [IW-1:0]       scan_idx;
  logic                frame_start;

  modport master (
    output value, dp_in, load, lz_blank,
    input  seg, dp, en, scan_idx, frame_start
  );

  modport slave (
    input  value, dp_in, load, lz_blank,
    output seg, dp, en, scan_idx, frame_start
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment scanner with hex encoding, per-slot blanking
// window, double-buffered loading, leading-zero blanking and selectable
// output polarities.
// Ports:
//   CLK  system clock
//   rst  synchronous reset, active-high
//   bus  seg7_scan_mux_if.slave (data in, segment/enable/status out)
// All outputs are registered: outputs in cycle n+1 reflect (idx, tick) of
// cycle n.
module seg7_scan_mux #(
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned DWELL          = 64,
  parameter int unsigned BLANK          = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
  input logic            CLK,
  input logic            rst,
  seg7_scan_mux_if.slave bus
);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TW = $clog2(DWELL);
  localparam logic [6:0]        SEG_MASK = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] EN_MASK  = {DIGITS{EN_ACTIVE_LOW}};

  logic [TW-1:0]       tick_q, tick_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] stage_val_q, stage_val_d;
  logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;
  logic                first_q, first_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;
  logic                frame_start_q, frame_start_d;

  logic                last_tick, wrap, xfer, active, upper_zero, lz_hide, cur_dp;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   onehot;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    case (nib)
      4'h0: encode = 7'b1111110;
      4'h1: encode = 7'b0110000;
      4'h2: encode = 7'b1101101;
      4'h3: encode = 7'b1111001;
      4'h4: encode = 7'b0110011;
      4'h5: encode = 7'b1011011;
      4'h6: encode = 7'b1011111;
      4'h7: encode = 7'b1110000;
      4'h8: encode = 7'b1111111;
      4'h9: encode = 7'b1111011;
      4'hA: encode = 7'b1110111;
      4'hB: encode = 7'b0011111;
      4'hC: encode = 7'b1001110;
      4'hD: encode = 7'b0111101;
      4'hE: encode = 7'b1001111;
      default: encode = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    last_tick = (tick_q == TW'(DWELL - 1));
    wrap      = last_tick && (idx_q == IW'(DIGITS - 1));
    tick_d    = last_tick ? '0 : tick_q + TW'(1);
    idx_d     = idx_q;
    if (last_tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    first_d   = 1'b0;

    // Staging -> display only at the frame boundary; a load in the same
    // cycle lands in staging after the old staged data has moved across.
    xfer        = pending_q && (wrap || first_q);
    stage_val_d = stage_val_q;
    stage_dp_d  = stage_dp_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (xfer) begin
      disp_val_d = stage_val_q;
      disp_dp_d  = stage_dp_q;
      pending_d  = 1'b0;
    end
    if (bus.load) begin
      stage_val_d = bus.value;
      stage_dp_d  = bus.dp_in;
      pending_d   = 1'b1;
    end

    cur_nib = '0;
    cur_dp  = 1'b0;
    onehot  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      onehot[i] = (IW'(i) == idx_q);
      if (IW'(i) == idx_q) begin
        cur_nib = disp_val_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
      end
    end

    // A digit is a leading zero when it and every higher digit is zero and
    // none of them requests a decimal point.
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx_q) && (disp_val_q[4*i +: 4] != 4'h0 || disp_dp_q[i]))
        upper_zero = 1'b0;
    end
    lz_hide = bus.lz_blank && (idx_q != '0) && upper_zero;

    active        = 32'(tick_q) >= BLANK;
    en_d          = (active ? onehot : '0) ^ EN_MASK;
    seg_d         = ((active && !lz_hide) ? encode(cur_nib) : 7'b0000000) ^ SEG_MASK;
    dp_d          = (active && cur_dp) ^ SEG_ACTIVE_LOW;
    scan_idx_d    = idx_q;
    frame_start_d = (tick_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      tick_q        <= '0;
      idx_q         <= '0;
      stage_val_q   <= '0;
      stage_dp_q    <= '0;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      first_q       <= 1'b1;
      seg_q         <= SEG_MASK;
      dp_q          <= SEG_ACTIVE_LOW;
      en_q          <= EN_MASK;
      scan_idx_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      stage_val_q   <= stage_val_d;
      stage_dp_q    <= stage_dp_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      first_q       <= first_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      en_q          <= en_d;
      scan_idx_q    <= scan_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.en          = en_q;
  assign bus.scan_idx    = scan_idx_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux. Three instances share clock and reset:
//   a: DIGITS=2 DWELL=8 BLANK=2, segments active-high, enables active-low
//   b: DIGITS=4 DWELL=4 BLANK=1, same polarities (leading-zero blanking)
//   c: DIGITS=2 DWELL=8 BLANK=2, segments active-low, enables active-high
// Expected outputs are queued with the cycle at which they must appear and
// popped when the run reaches that cycle.
module tb_seg7_scan_mux;
  logic        CLK;
  logic        rst;
  int unsigned n_assert;
  int unsigned n_fail;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  seg7_scan_mux_if #(.DIGITS(2)) bus_a ();
  seg7_scan_mux_if #(.DIGITS(4)) bus_b ();
  seg7_scan_mux_if #(.DIGITS(2)) bus_c ();

  seg7_scan_mux #(.DIGITS(2), .DWELL(8), .BLANK(2), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b1))
    dut_a (.CLK(CLK), .rst(rst), .bus(bus_a));
  seg7_scan_mux #(.DIGITS(4), .DWELL(4), .BLANK(1), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b1))
    dut_b (.CLK(CLK), .rst(rst), .bus(bus_b));
  seg7_scan_mux #(.DIGITS(2), .DWELL(8), .BLANK(2), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b0))
    dut_c (.CLK(CLK), .rst(rst), .bus(bus_c));

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] en;
    logic       dp;
    logic       fs;
    logic [7:0] idx;
  } obs_t;

  typedef struct {
    int    inst;
    int    cyc;
    string name;
    obs_t  want;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1111110;  4'h1: enc = 7'b0110000;
      4'h2: enc = 7'b1101101;  4'h3: enc = 7'b1111001;
      4'h4: enc = 7'b0110011;  4'h5: enc = 7'b1011011;
      4'h6: enc = 7'b1011111;  4'h7: enc = 7'b1110000;
      4'h8: enc = 7'b1111111;  4'h9: enc = 7'b1111011;
      4'hA: enc = 7'b1110111;  4'hB: enc = 7'b0011111;
      4'hC: enc = 7'b1001110;  4'hD: enc = 7'b0111101;
      4'hE: enc = 7'b1001111;  default: enc = 7'b1000111;
    endcase
  endfunction

  task automatic push_exp(input int inst, input int cyc, input string name, input logic [6:0] seg,
                          input int en, input int dp, input int fs, input int idx);
    exp_t e;
    e.inst     = inst;
    e.cyc      = cyc;
    e.name     = name;
    e.want.seg = seg;
    e.want.en  = 8'(en);
    e.want.dp  = 1'(dp);
    e.want.fs  = 1'(fs);
    e.want.idx = 8'(idx);
    sb.push_back(e);
  endtask

  function automatic obs_t get_obs(input int inst);
    obs_t o;
    o = '0;
    case (inst)
      0: begin o.seg = bus_a.seg; o.en = 8'(bus_a.en); o.dp = bus_a.dp; o.fs = bus_a.frame_start; o.idx = 8'(bus_a.scan_idx); end
      1: begin o.seg = bus_b.seg; o.en = 8'(bus_b.en); o.dp = bus_b.dp; o.fs = bus_b.frame_start; o.idx = 8'(bus_b.scan_idx); end
      default: begin o.seg = bus_c.seg; o.en = 8'(bus_c.en); o.dp = bus_c.dp; o.fs = bus_c.frame_start; o.idx = 8'(bus_c.scan_idx); end
    endcase
    return o;
  endfunction

  task automatic wait_fs(input int inst, output bit ok);
    obs_t o;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      o = get_obs(inst);
      if (o.fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    int   t;
    int   en_w;
    sb.delete();
    rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      push_exp(0, c, "reset_a", 7'h00, 3, 0, 0, 0);
      push_exp(2, c, "reset_c", 7'h7F, 0, 1, 0, 0);
    end
    for (int c = 4; c <= 37; c++) begin
      t = (c - 4) % 16;
      if (t % 8 < 2) en_w = 3;
      else en_w = (t < 8) ? 2 : 1;
      push_exp(0, c, "first_frame", (t % 8 < 2) ? 7'h00 : 7'h7E, en_w, 0, (t == 0) ? 1 : 0, t / 8);
    end
    for (int c = 1; c <= 37; c++) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        o = get_obs(e.inst);
        n_assert++;
        if (o !== e.want) begin
          n_fail++;
          $display("FAIL %s c=%0d: got seg=%b en=%b dp=%b fs=%b idx=%0d, expected seg=%b en=%b dp=%b fs=%b idx=%0d",
                   e.name, c, o.seg, o.en, o.dp, o.fs, o.idx, e.want.seg, e.want.en, e.want.dp, e.want.fs, e.want.idx);
        end
      end
      if (c == 3) rst = 1'b0;
    end
  endtask

  task automatic test_encode();
    exp_t       e;
    obs_t       o;
    bit         ok;
    int         k;
    logic [7:0] pat;
    sb.delete();
    wait_fs(0, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL encode_sync: got no frame_start, expected one within 200 cycles"); end
    for (int c = 1; c <= 17 * 32; c++) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        o = get_obs(e.inst);
        n_assert++;
        if (o !== e.want) begin
          n_fail++;
          $display("FAIL %s c=%0d: got seg=%b en=%b dp=%b fs=%b idx=%0d, expected seg=%b en=%b dp=%b fs=%b idx=%0d",
                   e.name, c, o.seg, o.en, o.dp, o.fs, o.idx, e.want.seg, e.want.en, e.want.dp, e.want.fs, e.want.idx);
        end
      end
      bus_a.load = 1'b0;
      k = c / 32;
      if (c % 32 == 3 && k < 17) begin
        pat = (k == 16) ? 8'h3A : {4'((k + 5) % 16), 4'(k)};
        bus_a.value = pat;
        bus_a.load  = 1'b1;
        push_exp(0, c + 13, "encode_frame", 7'h00, 3, 0, 1, 0);
        push_exp(0, c + 15, "encode_d0", enc(pat[3:0]), 2, 0, 0, 0);
        push_exp(0, c + 23, "encode_d1", enc(pat[7:4]), 1, 0, 0, 1);
      end
    end
  endtask

  task automatic test_tear_free();
    exp_t e;
    obs_t o;
    bit   ok;
    sb.delete();
    wait_fs(0, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL tear_sync: got no frame_start, expected one within 200 cycles"); end
    for (int c = 1; c <= 75; c++) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        o = get_obs(e.inst);
        n_assert++;
        if (o !== e.want) begin
          n_fail++;
          $display("FAIL %s c=%0d: got seg=%b en=%b dp=%b fs=%b idx=%0d, expected seg=%b en=%b dp=%b fs=%b idx=%0d",
                   e.name, c, o.seg, o.en, o.dp, o.fs, o.idx, e.want.seg, e.want.en, e.want.dp, e.want.fs, e.want.idx);
        end
      end
      bus_a.load = 1'b0;
      case (c)
        11: begin
          bus_a.value = 8'h12; bus_a.load = 1'b1;
          push_exp(0, 12, "tear_old_d1", enc(4'h3), 1, 0, 0, 1);
          push_exp(0, 13, "tear_old_d1", enc(4'h3), 1, 0, 0, 1);
          push_exp(0, 16, "tear_frame", 7'h00, 3, 0, 1, 0);
          push_exp(0, 18, "tear_new_d0", enc(4'h2), 2, 0, 0, 0);
          push_exp(0, 26, "tear_new_d1", enc(4'h1), 1, 0, 0, 1);
        end
        27: begin
          bus_a.value = 8'h67; bus_a.load = 1'b1;
          push_exp(0, 34, "staged_d0", enc(4'h7), 2, 0, 0, 0);
          push_exp(0, 42, "staged_d1", enc(4'h6), 1, 0, 0, 1);
        end
        30: begin
          bus_a.value = 8'h45; bus_a.load = 1'b1;
          push_exp(0, 50, "wrap_load_d0", enc(4'h5), 2, 0, 0, 0);
          push_exp(0, 58, "wrap_load_d1", enc(4'h4), 1, 0, 0, 1);
        end
        51: begin
          bus_a.value = 8'h99; bus_a.load = 1'b1;
        end
        53: begin
          bus_a.value = 8'hAB; bus_a.load = 1'b1;
          push_exp(0, 66, "last_load_d0", enc(4'hB), 2, 0, 0, 0);
          push_exp(0, 74, "last_load_d1", enc(4'hA), 1, 0, 0, 1);
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_lz_blank();
    exp_t       e;
    obs_t       o;
    bit         ok;
    bit         do_push;
    logic [6:0] segs [4];
    logic [3:0] dps;
    logic [3:0] en4;
    sb.delete();
    bus_b.lz_blank = 1'b1;
    wait_fs(1, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL lz_sync: got no frame_start, expected one within 200 cycles"); end
    for (int c = 1; c <= 127; c++) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        o = get_obs(e.inst);
        n_assert++;
        if (o !== e.want) begin
          n_fail++;
          $display("FAIL %s c=%0d: got seg=%b en=%b dp=%b fs=%b idx=%0d, expected seg=%b en=%b dp=%b fs=%b idx=%0d",
                   e.name, c, o.seg, o.en, o.dp, o.fs, o.idx, e.want.seg, e.want.en, e.want.dp, e.want.fs, e.want.idx);
        end
      end
      bus_b.load = 1'b0;
      do_push    = 1'b1;
      segs       = '{7'h00, 7'h00, 7'h00, 7'h00};
      dps        = 4'b0000;
      case (c)
        3: begin
          bus_b.value = 16'h0050; bus_b.dp_in = 4'b0000; bus_b.load = 1'b1;
          segs = '{enc(4'h0), enc(4'h5), 7'h00, 7'h00};
        end
        35: begin
          bus_b.dp_in = 4'b0100; bus_b.load = 1'b1;
          segs = '{enc(4'h0), enc(4'h5), enc(4'h0), 7'h00};
          dps  = 4'b0100;
        end
        67: begin
          bus_b.value = 16'h0000; bus_b.dp_in = 4'b0000; bus_b.load = 1'b1;
          segs = '{enc(4'h0), 7'h00, 7'h00, 7'h00};
        end
        99: begin
          bus_b.lz_blank = 1'b0;
          segs = '{enc(4'h0), enc(4'h0), enc(4'h0), enc(4'h0)};
        end
        default: do_push = 1'b0;
      endcase
      if (do_push) begin
        push_exp(1, c + 13, "lz_frame", 7'h00, 15, 0, 1, 0);
        for (int s = 0; s < 4; s++) begin
          en4    = 4'hF;
          en4[s] = 1'b0;
          push_exp(1, c + 14 + 4 * s, "lz_digit", segs[s], int'(en4), int'(dps[s]), 0, s);
        end
      end
    end
  endtask

  task automatic test_polarity();
    exp_t e;
    obs_t o;
    bit   ok;
    sb.delete();
    wait_fs(2, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL pol_sync: got no frame_start, expected one within 200 cycles"); end
    for (int c = 1; c <= 27; c++) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        o = get_obs(e.inst);
        n_assert++;
        if (o !== e.want) begin
          n_fail++;
          $display("FAIL %s c=%0d: got seg=%b en=%b dp=%b fs=%b idx=%0d, expected seg=%b en=%b dp=%b fs=%b idx=%0d",
                   e.name, c, o.seg, o.en, o.dp, o.fs, o.idx, e.want.seg, e.want.en, e.want.dp, e.want.fs, e.want.idx);
        end
      end
      bus_c.load = 1'b0;
      if (c == 3) begin
        bus_c.value = 8'h08; bus_c.load = 1'b1;
        push_exp(2, 16, "pol_blank0", 7'h7F, 0, 1, 1, 0);
        push_exp(2, 18, "pol_d0", 7'b0000000, 1, 1, 0, 0);
        push_exp(2, 24, "pol_blank1", 7'h7F, 0, 1, 0, 1);
        push_exp(2, 26, "pol_d1", 7'b0000001, 2, 1, 0, 1);
      end
    end
  endtask

  task automatic test_reset_midscan();
    exp_t e;
    obs_t o;
    bit   ok;
    sb.delete();
    wait_fs(0, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL midrst_sync: got no frame_start, expected one within 200 cycles"); end
    push_exp(0, 10, "pre_rst_d1", enc(4'hA), 1, 0, 0, 1);
    push_exp(0, 12, "pre_rst_d1", enc(4'hA), 1, 0, 0, 1);
    for (int c = 1; c <= 31; c++) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        o = get_obs(e.inst);
        n_assert++;
        if (o !== e.want) begin
          n_fail++;
          $display("FAIL %s c=%0d: got seg=%b en=%b dp=%b fs=%b idx=%0d, expected seg=%b en=%b dp=%b fs=%b idx=%0d",
                   e.name, c, o.seg, o.en, o.dp, o.fs, o.idx, e.want.seg, e.want.en, e.want.dp, e.want.fs, e.want.idx);
        end
      end
      if (c == 12) begin
        rst = 1'b1;
        push_exp(0, 13, "midrst_inactive", 7'h00, 3, 0, 0, 0);
        push_exp(0, 14, "midrst_restart", 7'h00, 3, 0, 1, 0);
        push_exp(0, 16, "midrst_cleared_d0", enc(4'h0), 2, 0, 0, 0);
        push_exp(0, 24, "midrst_cleared_d1", enc(4'h0), 1, 0, 0, 1);
        push_exp(0, 30, "midrst_period", 7'h00, 3, 0, 1, 0);
      end
      if (c == 13) rst = 1'b0;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus_a.value = '0; bus_a.dp_in = '0; bus_a.load = 1'b0; bus_a.lz_blank = 1'b0;
    bus_b.value = '0; bus_b.dp_in = '0; bus_b.load = 1'b0; bus_b.lz_blank = 1'b0;
    bus_c.value = '0; bus_c.dp_in = '0; bus_c.load = 1'b0; bus_c.lz_blank = 1'b0;
    test_reset();
    test_encode();
    test_tear_free();
    test_lz_blank();
    test_polarity();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, expected summary line");
    $fatal(1, "time limit");
  end
endmodule
